// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO block with per-bit output enables and edge-triggered interrupts.
// Every access terminates one cycle after it is sampled, so back-to-back traffic runs at one access per two cycles.
module wb_gpio_irq #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] POL_RST = {WIDTH{1'b1}}
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_inta_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o
);

  localparam logic [2:0] ADR_IN  = 3'd0;
  localparam logic [2:0] ADR_OUT = 3'd1;
  localparam logic [2:0] ADR_OE  = 3'd2;
  localparam logic [2:0] ADR_IE  = 3'd3;
  localparam logic [2:0] ADR_POL = 3'd4;
  localparam logic [2:0] ADR_IS  = 3'd5;

  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             inta_q, inta_d;
  logic [31:0]      dat_q, dat_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] is_q, is_d;
  logic [WIDTH-1:0] sync1_q, in_q, prev_q;
  logic [1:0]       armCnt_q, armCnt_d;

  logic             req;
  logic             adrValid;
  logic             wrEn;
  logic             armed;
  logic [31:0]      laneMask;
  logic [31:0]      rdData;
  logic [WIDTH-1:0] wMask;
  logic [WIDTH-1:0] wData;
  logic [WIDTH-1:0] isClr;
  logic [WIDTH-1:0] edgeDet;
  logic [WIDTH-1:0] edgeSet;

  // The pending termination blocks a second request so each access is taken exactly once.
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign adrValid = ~(wb_adr_i[2] & wb_adr_i[1]);
  assign wrEn     = req & wb_we_i & adrValid;

  assign laneMask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wMask    = laneMask[WIDTH-1:0];
  assign wData    = wb_dat_i[WIDTH-1:0];

  // Edges are ignored until the arm counter saturates, hiding the synchronizer filling up after reset.
  assign armed    = (armCnt_q == 2'd3);
  assign armCnt_d = armed ? armCnt_q : armCnt_q + 2'd1;
  assign edgeDet  = (pol_q & in_q & ~prev_q) | (~pol_q & ~in_q & prev_q);
  assign edgeSet  = armed ? edgeDet : '0;

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    ie_d  = ie_q;
    pol_d = pol_q;
    isClr = '0;
    if (wrEn) begin
      case (wb_adr_i)
        ADR_OUT: out_d = (out_q & ~wMask) | (wData & wMask);
        ADR_OE:  oe_d  = (oe_q  & ~wMask) | (wData & wMask);
        ADR_IE:  ie_d  = (ie_q  & ~wMask) | (wData & wMask);
        ADR_POL: pol_d = (pol_q & ~wMask) | (wData & wMask);
        ADR_IS:  isClr = wData & wMask;
        default: isClr = '0;
      endcase
    end
    // A new edge on the same clock as a clear keeps the bit set.
    is_d = (is_q & ~isClr) | edgeSet;
  end

  always_comb begin
    rdData = '0;
    case (wb_adr_i)
      ADR_IN:  rdData[WIDTH-1:0] = in_q;
      ADR_OUT: rdData[WIDTH-1:0] = out_q;
      ADR_OE:  rdData[WIDTH-1:0] = oe_q;
      ADR_IE:  rdData[WIDTH-1:0] = ie_q;
      ADR_POL: rdData[WIDTH-1:0] = pol_q;
      ADR_IS:  rdData[WIDTH-1:0] = is_q;
      default: rdData = '0;
    endcase
  end

  assign ack_d  = req & adrValid;
  assign err_d  = req & ~adrValid;
  assign dat_d  = (req & ~wb_we_i & adrValid) ? rdData : '0;
  assign inta_d = |(is_q & ie_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      inta_q   <= 1'b0;
      dat_q    <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      ie_q     <= '0;
      pol_q    <= POL_RST;
      is_q     <= '0;
      sync1_q  <= '0;
      in_q     <= '0;
      prev_q   <= '0;
      armCnt_q <= 2'd0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      inta_q   <= inta_d;
      dat_q    <= dat_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      ie_q     <= ie_d;
      pol_q    <= pol_d;
      is_q     <= is_d;
      sync1_q  <= gpio_i;
      in_q     <= sync1_q;
      prev_q   <= in_q;
      armCnt_q <= armCnt_d;
    end
  end

  // Terminations are masked by cyc so a master that abandons a cycle never sees a stray ack.
  assign wb_ack_o  = ack_q & wb_cyc_i;
  assign wb_err_o  = err_q & wb_cyc_i;
  assign wb_dat_o  = wb_ack_o ? dat_q : '0;
  assign wb_inta_o = inta_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed self-checking bench for wb_gpio_irq; a WIDTH=8 copy shares the bus to check narrow builds.
module tb_wb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  adr = 3'd0;
  logic [31:0] datI = '0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] gpioIn = '0;

  logic [31:0] datO, gpioOut, gpioOe;
  logic        ack, err, inta;
  logic [31:0] datO8;
  logic [7:0]  gpioOut8, gpioOe8;
  logic        ack8, err8, inta8;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  wb_gpio_irq dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(datI), .wb_sel_i(sel), .wb_dat_o(datO), .wb_ack_o(ack),
    .wb_err_o(err), .wb_inta_o(inta), .gpio_i(gpioIn), .gpio_o(gpioOut), .gpio_oe_o(gpioOe)
  );

  wb_gpio_irq #(.WIDTH(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(datI), .wb_sel_i(sel), .wb_dat_o(datO8), .wb_ack_o(ack8),
    .wb_err_o(err8), .wb_inta_o(inta8), .gpio_i(gpioIn[7:0]), .gpio_o(gpioOut8), .gpio_oe_o(gpioOe8)
  );

  // Called 1ns after a rising edge; samples 1ns after the sampling edge, then idles one cycle.
  task automatic wbAccess(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic [31:0] rd8, output logic gotAck,
                          output logic gotErr, output logic intaAtAck);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; datI = d; sel = s;
    @(posedge clk); #1;
    rd = datO; rd8 = datO8; gotAck = ack; gotErr = err; intaAtAck = inta;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = '0; sel = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    logic [31:0] expRd [6];
    expRd = '{32'h0000_0008, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    gpioIn = 32'h0000_0008;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({ack, err, inta, ack8, err8, inta8} !== 6'b0) $display("[TB] FAIL reset_ctrl: got %b required 000000", {ack, err, inta, ack8, err8, inta8});
    else passCount++;
    checkCount++;
    if (datO !== 32'h0) $display("[TB] FAIL reset_dat: got %h required 0", datO);
    else passCount++;
    checkCount++;
    if ({gpioOut, gpioOe} !== 64'h0) $display("[TB] FAIL reset_gpio: got out=%h oe=%h required 0", gpioOut, gpioOe);
    else passCount++;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int a = 0; a < 6; a++) begin
      wbAccess(1'b0, 3'(a), 32'h0, 4'hF, rd, rd8, gA, gE, gI);
      checkCount++;
      if ({gA, gE} !== 2'b10) $display("[TB] FAIL reset_rd_term adr=%0d: got ack/err %b%b required 10", a, gA, gE);
      else passCount++;
      checkCount++;
      if (rd !== expRd[a]) $display("[TB] FAIL reset_rd adr=%0d: got %h required %h", a, rd, expRd[a]);
      else passCount++;
      checkCount++;
      if (rd8 !== (expRd[a] & 32'hFF)) $display("[TB] FAIL reset_rd8 adr=%0d: got %h required %h", a, rd8, expRd[a] & 32'hFF);
      else passCount++;
    end
    checkCount++;
    if (inta !== 1'b0) $display("[TB] FAIL reset_no_irq: got %b required 0", inta);
    else passCount++;
  endtask

  task automatic test_out_oe();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    wbAccess(1'b1, 3'd1, 32'hA5A5_1234, 4'b0101, rd, rd8, gA, gE, gI);
    checkCount++;
    if (gA !== 1'b1) $display("[TB] FAIL out_wr_ack: got %b required 1", gA);
    else passCount++;
    checkCount++;
    if (gpioOut !== 32'h00A5_0034) $display("[TB] FAIL gpio_o_lanes: got %h required 00a50034", gpioOut);
    else passCount++;
    checkCount++;
    if (gpioOut8 !== 8'h34) $display("[TB] FAIL gpio_o_w8: got %h required 34", gpioOut8);
    else passCount++;
    wbAccess(1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (gpioOe !== 32'hFFFF_FFFF) $display("[TB] FAIL gpio_oe: got %h required ffffffff", gpioOe);
    else passCount++;
    wbAccess(1'b0, 3'd1, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h00A5_0034) $display("[TB] FAIL out_readback: got %h required 00a50034", rd);
    else passCount++;
    wbAccess(1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, rd, rd8, gA, gE, gI);
    wbAccess(1'b0, 3'd0, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h0000_0008) $display("[TB] FAIL in_write_ignored: got %h required 00000008", rd);
    else passCount++;
  endtask

  task automatic test_irq_edge();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    wbAccess(1'b1, 3'd4, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    wbAccess(1'b1, 3'd3, 32'h8, 4'hF, rd, rd8, gA, gE, gI);
    gpioIn = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (inta !== 1'b0) $display("[TB] FAIL inta_early: got %b required 0 at T+3", inta);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (inta !== 1'b1) $display("[TB] FAIL inta_rise: got %b required 1 at T+4", inta);
    else passCount++;
    wbAccess(1'b0, 3'd5, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h8) $display("[TB] FAIL is_after_fall: got %h required 00000008", rd);
    else passCount++;
  endtask

  task automatic test_is_set_clear();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    gpioIn = 32'h8;
    repeat (4) @(posedge clk);
    #1;
    gpioIn = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    wbAccess(1'b1, 3'd5, 32'h8, 4'hF, rd, rd8, gA, gE, gI);
    wbAccess(1'b0, 3'd5, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h8) $display("[TB] FAIL is_set_wins: got %h required 00000008", rd);
    else passCount++;
    wbAccess(1'b1, 3'd5, 32'h8, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (gI !== 1'b1) $display("[TB] FAIL inta_at_clear: got %b required 1", gI);
    else passCount++;
    checkCount++;
    if (inta !== 1'b0) $display("[TB] FAIL inta_fall: got %b required 0", inta);
    else passCount++;
    wbAccess(1'b0, 3'd5, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h0) $display("[TB] FAIL is_cleared: got %h required 0", rd);
    else passCount++;
  endtask

  task automatic test_err();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    wbAccess(1'b0, 3'd6, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if ({gA, gE, rd} !== {2'b01, 32'h0}) $display("[TB] FAIL err_rd6: got ack/err %b%b dat %h required 01 0", gA, gE, rd);
    else passCount++;
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL err_one_cycle: got %b required 0", err);
    else passCount++;
    wbAccess(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if ({gA, gE} !== 2'b01) $display("[TB] FAIL err_wr6: got ack/err %b%b required 01", gA, gE);
    else passCount++;
    wbAccess(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if ({gA, gE} !== 2'b01) $display("[TB] FAIL err_wr7: got ack/err %b%b required 01", gA, gE);
    else passCount++;
    wbAccess(1'b0, 3'd1, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h00A5_0034) $display("[TB] FAIL err_no_out_change: got %h required 00a50034", rd);
    else passCount++;
    wbAccess(1'b0, 3'd3, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h8) $display("[TB] FAIL err_no_ie_change: got %h required 00000008", rd);
    else passCount++;
    wbAccess(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rd, rd8, gA, gE, gI);
    wbAccess(1'b0, 3'd1, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd8 !== 32'h0000_00FF) $display("[TB] FAIL w8_out_readback: got %h required 000000ff", rd8);
    else passCount++;
    checkCount++;
    if (rd !== 32'hFFFF_FFFF) $display("[TB] FAIL w32_out_readback: got %h required ffffffff", rd);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; datI = 32'h1122_3344; sel = 4'hF;
    @(posedge clk);
    #1;
    checkCount++;
    if (ack !== 1'b1) $display("[TB] FAIL b2b_first_ack: got %b required 1", ack);
    else passCount++;
    we = 1'b0; datI = '0;
    @(posedge clk);
    #1;
    checkCount++;
    if ({ack, err} !== 2'b00) $display("[TB] FAIL b2b_gap: got ack/err %b%b required 00", ack, err);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if ({ack, datO} !== {1'b1, 32'h1122_3344}) $display("[TB] FAIL b2b_second_rd: got ack %b dat %h required 1 11223344", ack, datO);
    else passCount++;
    cyc = 1'b0; stb = 1'b0; sel = 4'h0;
    @(posedge clk);
    #1;
    checkCount++;
    if (datO !== 32'h0) $display("[TB] FAIL dat_idle_zero: got %h required 0", datO);
    else passCount++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, rd8;
    logic        gA, gE, gI;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; datI = 32'hDEAD_BEEF; sel = 4'hF;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkCount++;
    if ({ack, err} !== 2'b00) $display("[TB] FAIL abort_no_term: got ack/err %b%b required 00", ack, err);
    else passCount++;
    checkCount++;
    if (gpioOut !== 32'h0) $display("[TB] FAIL abort_out_reset: got %h required 0", gpioOut);
    else passCount++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = '0; sel = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wbAccess(1'b0, 3'd1, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'h0) $display("[TB] FAIL abort_out_readback: got %h required 0", rd);
    else passCount++;
    wbAccess(1'b0, 3'd4, 32'h0, 4'hF, rd, rd8, gA, gE, gI);
    checkCount++;
    if (rd !== 32'hFFFF_FFFF) $display("[TB] FAIL abort_pol_reset: got %h required ffffffff", rd);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_out_oe();
    test_irq_edge();
    test_is_set_clear();
    test_err();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
